// File: rtl/des_host_pkg.sv
// Shared definitions for the descrypt host-bus job controller:
// FSM state encoding, frame sizes and status-port bit positions.
package des_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_READY  = 3'd4
    } job_state_t;

    localparam int SALT_BYTES    = 2;
    localparam int DES_KEY_BYTES = 8;
    localparam int DES_RES_BYTES = 8;

    localparam int PD_BUSY      = 0;
    localparam int PD_RES_VALID = 1;
    localparam int PD_BAD_SALT  = 2;
    localparam int PD_OVERRUN   = 3;
    localparam int PD_IDX_LSB   = 4;

endpackage

// File: rtl/des_job_ctrl_if.sv
// Host slow-bus pins plus the DES core launch/result signals, bundled so the
// controller sees one port; slave = controller side, master = host/core side.
interface des_job_ctrl_if;

    logic        SLOWCLK;
    logic        CS;
    logic        WR;
    logic        RD;
    logic [7:0]  pc;
    logic [7:0]  pb;
    logic [7:0]  pd;
    logic        core_start;
    logic [11:0] core_salt;
    logic [63:0] core_key;
    logic        core_done;
    logic [63:0] core_result;

    modport slave (
        input  SLOWCLK, CS, WR, RD, pc, core_done, core_result,
        output pb, pd, core_start, core_salt, core_key
    );

    modport master (
        input  pb, pd, core_start, core_salt, core_key,
        output SLOWCLK, CS, WR, RD, pc, core_done, core_result
    );

endinterface

// File: rtl/des_salt_decode.sv
// Maps one crypt(3) salt character from the ./0-9A-Za-z alphabet to its 6-bit
// value; anything outside the alphabet decodes to 0 and raises o_invalid.
module des_salt_decode (
    input  logic [7:0] i_char,
    output logic [5:0] o_val,
    output logic       o_invalid
);

    always_comb begin
        o_val     = 6'd0;
        o_invalid = 1'b0;
        if (i_char == 8'h2E) begin
            o_val = 6'd0;
        end else if (i_char == 8'h2F) begin
            o_val = 6'd1;
        end else if (i_char >= 8'h30 && i_char <= 8'h39) begin
            o_val = 6'(i_char - 8'd46);
        end else if (i_char >= 8'h41 && i_char <= 8'h5A) begin
            o_val = 6'(i_char - 8'd53);
        end else if (i_char >= 8'h61 && i_char <= 8'h7A) begin
            o_val = 6'(i_char - 8'd59);
        end else begin
            o_invalid = 1'b1;
        end
    end

endmodule

// File: rtl/des_job_ctrl.sv
// Host-bus sequencer for one descrypt job: collects salt+key bytes, pulses
// core_start, waits for core_done and streams the 64-bit result back on pb.
module des_job_ctrl
    import des_host_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int KEY_BYTES   = DES_KEY_BYTES,
    parameter int RES_BYTES   = DES_RES_BYTES
) (
    input  logic           CLK,
    input  logic           RESET,
    des_job_ctrl_if.slave  host
);

    localparam int FRAME_BYTES = SALT_BYTES + KEY_BYTES;

    logic [SYNC_STAGES-1:0] r_slow_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_wr_sync;
    logic [SYNC_STAGES-1:0] r_rd_sync;
    logic [7:0]             r_pc_sync [SYNC_STAGES];
    logic                   r_slow_prev;

    job_state_t  r_state;
    logic [3:0]  r_idx;
    logic [11:0] r_core_salt;
    logic [63:0] r_core_key;
    logic [63:0] r_result;
    logic        r_result_valid;
    logic        r_bad_salt;
    logic        r_overrun;
    logic        r_busy;
    logic        r_core_start;
    logic [7:0]  r_pb;

    logic        w_slow, w_cs, w_wr, w_rd;
    logic [7:0]  w_pc;
    logic        w_strobe, w_wr_strobe, w_rd_strobe, w_clash;
    logic        w_frame_open, w_new_frame, w_store;
    logic [3:0]  w_pos;
    logic [2:0]  w_slot;
    logic [63:0] w_key_mask;
    logic [7:0]  w_key_byte;
    logic [7:0]  w_res_byte;
    logic [5:0]  w_dec_val;
    logic        w_dec_bad;
    logic [7:0]  w_pd;

    // All host pins share the same depth so pc stays aligned with its strobe.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_slow_sync <= '0;
            r_cs_sync   <= '0;
            r_wr_sync   <= '0;
            r_rd_sync   <= '0;
            r_slow_prev <= 1'b0;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_pc_sync[k] <= 8'h00;
            end
        end else begin
            r_slow_sync[0] <= host.SLOWCLK;
            r_cs_sync[0]   <= host.CS;
            r_wr_sync[0]   <= host.WR;
            r_rd_sync[0]   <= host.RD;
            r_pc_sync[0]   <= host.pc;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_slow_sync[k] <= r_slow_sync[k-1];
                r_cs_sync[k]   <= r_cs_sync[k-1];
                r_wr_sync[k]   <= r_wr_sync[k-1];
                r_rd_sync[k]   <= r_rd_sync[k-1];
                r_pc_sync[k]   <= r_pc_sync[k-1];
            end
            r_slow_prev <= w_slow;
        end
    end

    assign w_slow = r_slow_sync[SYNC_STAGES-1];
    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_wr   = r_wr_sync[SYNC_STAGES-1];
    assign w_rd   = r_rd_sync[SYNC_STAGES-1];
    assign w_pc   = r_pc_sync[SYNC_STAGES-1];

    assign w_strobe    = (w_slow != r_slow_prev) && w_cs;
    assign w_wr_strobe = w_strobe && w_wr && !w_rd;
    assign w_rd_strobe = w_strobe && w_rd && !w_wr;
    assign w_clash     = w_strobe && w_wr && w_rd;

    // A write strobe from IDLE or READY always opens a fresh frame at byte 0.
    assign w_frame_open = (r_state == ST_LOAD) && w_cs && w_wr;
    assign w_new_frame  = w_wr_strobe && (r_state == ST_IDLE || r_state == ST_READY);
    assign w_store      = w_new_frame || (w_frame_open && w_wr_strobe);
    assign w_pos        = w_new_frame ? 4'd0 : r_idx;
    assign w_slot       = w_pos[2:0] - 3'(SALT_BYTES);
    assign w_key_mask   = 64'hFF00_0000_0000_0000 >> {w_slot, 3'b000};
    assign w_key_byte   = {w_pc[6:0], 1'b0};
    assign w_res_byte   = 8'(r_result >> {~r_idx[2:0], 3'b000});

    des_salt_decode u_salt_decode (
        .i_char    (w_pc),
        .o_val     (w_dec_val),
        .o_invalid (w_dec_bad)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state        <= ST_IDLE;
            r_idx          <= 4'd0;
            r_core_salt    <= 12'h000;
            r_core_key     <= 64'h0;
            r_result       <= 64'h0;
            r_result_valid <= 1'b0;
            r_bad_salt     <= 1'b0;
            r_overrun      <= 1'b0;
            r_busy         <= 1'b0;
            r_core_start   <= 1'b0;
            r_pb           <= 8'h00;
        end else begin
            r_core_start <= 1'b0;
            r_pb         <= r_result_valid ? w_res_byte : 8'h00;
            if (w_clash) begin
                r_overrun <= 1'b1;
            end

            // Salt/key registers only move while a frame is being written,
            // so they stay frozen from launch until the core answers.
            if (w_store) begin
                if (w_pos == 4'd0) begin
                    r_core_salt[5:0] <= w_dec_val;
                    r_bad_salt       <= w_dec_bad;
                    r_overrun        <= 1'b0;
                end else if (w_pos == 4'd1) begin
                    r_core_salt[11:6] <= w_dec_val;
                    if (w_dec_bad) begin
                        r_bad_salt <= 1'b1;
                    end
                end else begin
                    r_core_key <= (r_core_key & ~w_key_mask) | ({8{w_key_byte}} & w_key_mask);
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_new_frame) begin
                        r_idx   <= 4'd1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!w_frame_open) begin
                        r_idx   <= 4'd0;
                        r_state <= ST_IDLE;
                    end else if (w_wr_strobe) begin
                        if (r_idx == 4'(FRAME_BYTES - 1)) begin
                            r_idx   <= 4'd0;
                            r_busy  <= 1'b1;
                            r_state <= ST_LAUNCH;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                ST_LAUNCH: begin
                    r_core_start <= 1'b1;
                    r_state      <= ST_WAIT;
                    if (w_wr_strobe) begin
                        r_overrun <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_wr_strobe) begin
                        r_overrun <= 1'b1;
                    end
                    if (host.core_done) begin
                        r_result       <= host.core_result;
                        r_result_valid <= 1'b1;
                        r_busy         <= 1'b0;
                        r_idx          <= 4'd0;
                        r_state        <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (w_new_frame) begin
                        r_result_valid <= 1'b0;
                        r_idx          <= 4'd1;
                        r_state        <= ST_LOAD;
                    end else if (w_rd_strobe) begin
                        if (r_idx == 4'(RES_BYTES - 1)) begin
                            r_result_valid <= 1'b0;
                            r_idx          <= 4'd0;
                            r_state        <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_pd                = 8'h00;
        w_pd[PD_BUSY]       = r_busy;
        w_pd[PD_RES_VALID]  = r_result_valid;
        w_pd[PD_BAD_SALT]   = r_bad_salt;
        w_pd[PD_OVERRUN]    = r_overrun;
        w_pd[PD_IDX_LSB+:4] = r_idx;
    end

    assign host.pb         = r_pb;
    assign host.pd         = w_pd;
    assign host.core_start = r_core_start;
    assign host.core_salt  = r_core_salt;
    assign host.core_key   = r_core_key;

endmodule

// File: doc/des_job_ctrl.md
Name: des_job_ctrl

Overview:
- Sequences one descrypt job on the DES core.
- Receives salt and key bytes from the host over the slow parallel bus (pc, CS, WR, RD, SLOWCLK) and decodes them.
- Launches the core, captures the 64-bit result and streams it back byte-wise on pb.
- Sits between the host-bus pins of main and the DES pipeline; the only owner of core_start.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for SLOWCLK/CS/WR/RD/pc.
- KEY_BYTES, 8, key bytes per write frame.
- RES_BYTES, 8, result bytes per read frame.

Ports:
- CLK  in  1  core clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SLOWCLK  in  1  host byte strobe; every toggle (either edge) is one transfer.
- CS  in  1  host chip select.
- WR  in  1  host write frame.
- RD  in  1  host read frame.
- pc  in  8  host write data.
- pb  out  8  host read data.
- pd  out  8  status: [0] busy, [1] result_valid, [2] bad_salt, [3] overrun, [7:4] byte index.
- core_start  out  1  one-cycle launch pulse.
- core_salt  out  12  decoded salt.
- core_key  out  64  packed key.
- core_done  in  1  one-cycle pulse, result valid.
- core_result  in  64  DES output.

Behaviour:
- Reset values: all outputs 0, FSM IDLE, counters 0, flags 0.
- Input capture:
  - SLOWCLK, CS, WR, RD and pc each pass through a SYNC_STAGES flop chain.
  - A strobe is a change of the synced SLOWCLK versus its previous sample.
  - Strobes with CS=0 are ignored.
  - A strobe with WR=RD=1 is ignored and sets overrun.
- Write frame: 2 salt bytes then KEY_BYTES key bytes; the byte index counts 0..9.
- Salt decode per char:
  - '.'→0, '/'→1, '0'-'9'→2-11, 'A'-'Z'→12-37, 'a'-'z'→38-63.
  - Any other char → 0 and sets bad_salt (sticky until the next frame start).
  - core_salt = dec(byte0) | dec(byte1)<<6.
- Key packing: byte i is stored as (pc<<1)&8'hFE into core_key[63-8i -: 8].
- FSM:
  - IDLE: a write strobe stores byte 0 → LOAD.
  - LOAD: stores bytes; the 10th byte → LAUNCH. If CS falls or WR drops mid-frame, the frame is aborted: index=0 → IDLE.
  - LAUNCH: core_start=1 for exactly one cycle; core_salt and core_key are held stable from here until core_done → WAIT.
  - WAIT: busy=1. On core_done, latch core_result, set result_valid, index=0 → READY. Write strobes here are dropped and set overrun.
  - READY: pb = result byte [63-8·index -: 8] (MSB first), valid the cycle after the synced index update.
    - Each read strobe increments index.
    - After RES_BYTES reads, clear result_valid → IDLE.
    - A write strobe aborts the readout and starts a new frame at byte 0.
- Read strobe when result_valid=0: pb=8'h00, index unchanged.
- core_done outside WAIT is ignored.
- Latency:
  - Strobe-to-register: SYNC_STAGES+1 CLK cycles.
  - core_start: 1 cycle after the 10th byte is registered.
- RESET mid-operation clears everything immediately, including any pending result. The core must be reset with the same RESET.
- pd[7:4] = byte index mod 16.

Decomposition:
- Shared package des_host_pkg holds:
  - the FSM state enum,
  - SALT_BYTES=2, DES_KEY_BYTES=8, DES_RES_BYTES=8,
  - the status bit positions for pd.
- One sub-module, des_salt_decode: combinational ascii64→6-bit value plus invalid flag, instantiated twice or time-shared.
- Synchronizer and edge detect stay inline.

Test Plan:
- Salt "21" + key "abcdefgh" (0x61..0x68), WR frame with CS=1 → core_start one pulse:
  - core_salt=12'h0C4;
  - core_key=64'hC2C4C6C8CACCCED0;
  - busy=1 until core_done.
- Core stub returns 64'h18DF29DCDBAB5B10 after 25 cycles; RD frame of 8 strobes:
  - pb sequence 18,DF,29,DC,DB,AB,5B,10;
  - result_valid cleared after the 8th strobe.
- Salt byte 0x21 ('!') → bad_salt=1, salt field 0; job still launches; the flag clears on the next frame's first byte.
- CS deasserted after 5 bytes, then a full frame → no core_start for the partial frame; the full frame launches with the correct key.
- Write strobes during WAIT → overrun=1, core_key unchanged; a read with no result → pb=00.
- RESET pulse during WAIT, then core_done → result ignored; pb=00, pd=00, FSM in IDLE.
